i2c_addr_matcher: RTL and testbench
===================================

I2C_ADDR_MATCHER -- requirements
Module: i2c_addr_matcher

Interface
REQ-001 Parameter NUM_ADDR, default 2, number of programmable slave address slots (1..8).
REQ-002 Parameter IDX_W, default $clog2(NUM_ADDR) floored at 1, width of match_idx.
REQ-003 FPGA_clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; rst=0 sampled on a FPGA_clk edge resets the block.
REQ-005 SCL, SCL_prev  input  1 each  current and one-cycle-delayed synchronised SCL.
REQ-006 SDA  input  1  synchronised SDA.
REQ-007 enable  input  1  high from START detect until STOP or repeated START; low aborts.
REQ-008 addr_table  input  NUM_ADDR x 10  slot addresses; 7-bit slots use [6:0].
REQ-009 addr_mask  input  NUM_ADDR x 10  per-bit don't-care mask; 1 means ignore the bit.
REQ-010 addr_is10  input  NUM_ADDR  slot is a 10-bit address when set.
REQ-011 done  output  1  one-cycle pulse when address phase ends, matched or not.
REQ-012 selected  output  1  level; slave addressed; valid with done, held while enable=1.
REQ-013 match_idx  output  IDX_W  index of the matched slot, held with selected.
REQ-014 rw  output  1  captured R/W bit of the final header byte.
REQ-015 is_10bit  output  1  match came through the 10-bit path.
REQ-016 ack_drive  output  1  request to pull SDA low during an ACK bit.

Function
REQ-017 Rising SCL edge = SCL & ~SCL_prev; falling edge = ~SCL & SCL_prev; SDA is sampled only on rising edges, MSB first.
REQ-018 States: IDLE, BYTE1, ACK1, BYTE2, ACK2, FINISH.
REQ-019 IDLE -> BYTE1 when enable=1; bit counter is cleared on entry to BYTE1 and BYTE2.
REQ-020 BYTE1 ends after 8 rising edges; byte1[0] is captured into rw.
REQ-021 7-bit match: a slot with addr_is10=0 matches when (byte1[7:1] ^ addr_table[6:0]) & ~addr_mask[6:0] == 0.
REQ-022 10-bit header: byte1[7:3]=5'b11110, and a slot with addr_is10=1 matches [9:8] against byte1[2:1] under the mask.
REQ-023 With any match after BYTE1, ack_drive=1 from the 8th falling edge to the 9th falling edge (state ACK1).
REQ-024 Without any match after BYTE1, FINISH is entered with selected=0 and ack_drive is never asserted.
REQ-025 For a 10-bit header with rw=0, ACK1 -> BYTE2; the full 10-bit compare on {byte1[2:1], byte2} picks the final slot; a match gives ACK2 with the same ack timing, a miss gives FINISH unselected.
REQ-026 For a 10-bit header with rw=1 while the sticky last10_valid flag holds the previously matched slot, the block selects that slot after ACK1 with no BYTE2 (repeated-START read).
REQ-027 last10_valid is set on a 10-bit write match and cleared by reset, by a 7-bit transaction, or by a failed compare.
REQ-028 Several slots matching at once: the lowest index wins.
REQ-029 FINISH pulses done for exactly one cycle and then holds selected, match_idx, rw, and is_10bit until enable=0, then returns to IDLE.
REQ-030 enable=0 in any state returns to IDLE on the next clock, with ack_drive=0, selected=0, and no done pulse.
REQ-031 Total latency: done asserts one FPGA_clk after the final ACK falling edge, or after the 8th falling edge when there is no match.

Reset
REQ-032 Reset values: state IDLE, done=0, selected=0, match_idx=0, rw=0, is_10bit=0, ack_drive=0, last10_valid=0, bit counter 0.
REQ-033 Reset asserted mid-byte or mid-ACK releases SDA (ack_drive=0) on that same clock edge.

Configuration
REQ-034 Macro I2C_GENERAL_CALL_EN, when defined, adds output gen_call (1 bit) and treats byte1=8'h00 as a match with ack, selected=1, gen_call=1, match_idx=0.
REQ-035 Without I2C_GENERAL_CALL_EN, there is no gen_call port and 8'h00 matches only through the addr_table compare.

Structure
REQ-036 Package i2c_addr_matcher_pkg holds the state enum, HDR10 = 5'b11110, GEN_CALL_ADDR = 8'h00, and MAX_ADDR = 8.
REQ-037 A single sub-module i2c_bit_counter (4-bit, sync clear, enable) counts rising SCL edges.

Verification
REQ-038 Slot0=7'h42, bus byte 8'h84 -> ack on bit 9, done pulse, selected=1, match_idx=0, rw=0, is_10bit=0.
REQ-039 Slot1=10'h2A5 (10-bit), bytes 8'hF4 then 8'hA5 -> ack after both bytes, selected=1, match_idx=1, is_10bit=1.
REQ-040 After REQ-039, repeated START with byte 8'hF5 -> single ack, selected=1, rw=1, match_idx=1, no BYTE2.
REQ-041 Slot0=7'h40 with mask 7'h03, byte 8'h86 -> match; byte 8'h8A -> no ack, done pulse, selected=0.
REQ-042 enable dropped after 4 bits -> IDLE next clock, no done pulse; rst=0 during ACK -> ack_drive=0 on that edge.
REQ-043 With I2C_GENERAL_CALL_EN, byte 8'h00 -> ack, gen_call=1; without the macro and no slot 0 match, byte 8'h00 -> no ack.

Source files
------------

// File: rtl/i2c_addr_matcher_pkg.sv
// i2c_addr_matcher_pkg
// Shared definitions for the I2C slave address matcher: the address-phase
// state encoding, the 10-bit header prefix, the general-call byte and the
// maximum number of address slots.
package i2c_addr_matcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BYTE1,
        ACK1,
        BYTE2,
        ACK2,
        FINISH
    } state_t;

    localparam logic [4:0] HDR10         = 5'b11110;
    localparam logic [7:0] GEN_CALL_ADDR = 8'h00;
    localparam int         MAX_ADDR      = 8;

endpackage

// File: rtl/i2c_addr_matcher_bit_counter.sv
// i2c_bit_counter
// Counts rising SCL edges within one address byte.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-low reset
//   clear - synchronous clear, wins over en
//   en    - increment by one
//   count - current bit count
module i2c_bit_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    output logic [3:0] count
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/i2c_addr_matcher.sv
// i2c_addr_matcher
// Decodes the I2C address phase (7-bit, 10-bit and 10-bit repeated-START
// read) against a table of programmable slave addresses with per-bit masks,
// requests the ACK and reports the selected slot.
//
// Optional feature macro: I2C_GENERAL_CALL_EN adds the gen_call output and
// accepts byte 8'h00 as a general call (match_idx reported as 0).
//
// Ports:
//   FPGA_clk        - system clock, rising edge
//   rst             - synchronous active-low reset
//   SCL, SCL_prev   - synchronised SCL and its one-cycle-delayed copy
//   SDA             - synchronised SDA
//   enable          - high for the duration of a bus transaction
//   addr_table      - per-slot address (7-bit slots use [6:0])
//   addr_mask       - per-slot don't-care bits (1 = ignore)
//   addr_is10       - per-slot 10-bit flag
//   done            - one-cycle pulse at end of address phase
//   selected        - slave addressed, held until enable drops
//   match_idx       - matched slot index
//   rw              - R/W bit of the header byte
//   is_10bit        - match came through the 10-bit path
//   ack_drive       - pull SDA low for the ACK bit
//   gen_call        - general call received (I2C_GENERAL_CALL_EN only)
//
// state  | meaning
// IDLE   | waiting for enable
// BYTE1  | shifting the first address/header byte
// ACK1   | ACK bit after byte 1 (ack_drive high)
// BYTE2  | shifting the low 8 bits of a 10-bit address
// ACK2   | ACK bit after byte 2 (ack_drive high)
// FINISH | done pulsed, result held until enable drops
module i2c_addr_matcher
    import i2c_addr_matcher_pkg::*;
#(
    parameter int NUM_ADDR = 2,
    parameter int IDX_W    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input  logic                     FPGA_clk,
    input  logic                     rst,
    input  logic                     SCL,
    input  logic                     SCL_prev,
    input  logic                     SDA,
    input  logic                     enable,
    input  logic [NUM_ADDR-1:0][9:0] addr_table,
    input  logic [NUM_ADDR-1:0][9:0] addr_mask,
    input  logic [NUM_ADDR-1:0]      addr_is10,
    output logic                     done,
    output logic                     selected,
    output logic [IDX_W-1:0]         match_idx,
    output logic                     rw,
    output logic                     is_10bit,
    output logic                     ack_drive
`ifdef I2C_GENERAL_CALL_EN
    ,
    output logic                     gen_call
`endif
);

    state_t              state;
    logic                scl_rise;
    logic                scl_fall;
    logic [3:0]          bit_cnt;
    logic                cnt_clear;
    logic                cnt_en;
    logic                shifting;
    logic                byte_end;
    logic [7:0]          byte_sr;
    logic [1:0]          hdr_hi;
    logic                hdr_mode;
    logic                hdr_is10;
    logic                last10_valid;
    logic [IDX_W-1:0]    last_idx;
    logic [IDX_W-1:0]    pend_idx;
    logic                gc_hit;
    logic                hit7;
    logic                hit10;
    logic                rs_hit;
    logic [NUM_ADDR-1:0] hdr_hit;
    logic [IDX_W-1:0]    idx7;
    logic [IDX_W-1:0]    idx10;
    logic                b1_ack;
    logic [IDX_W-1:0]    b1_idx;

    assign scl_rise = SCL & ~SCL_prev;
    assign scl_fall = ~SCL & SCL_prev;
    assign shifting = (state == BYTE1) || (state == BYTE2);
    assign byte_end = (bit_cnt == 4'd8) && scl_fall;
    assign hdr_is10 = (byte_sr[7:3] == HDR10);

    assign cnt_clear = (state == IDLE) || (state == ACK1);
    assign cnt_en    = scl_rise && shifting && (bit_cnt < 4'd8);

    i2c_bit_counter u_bit_counter (
        .clk   (FPGA_clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (bit_cnt)
    );

`ifdef I2C_GENERAL_CALL_EN
    logic pend_gc;
    assign gc_hit = (byte_sr == GEN_CALL_ADDR);
`else
    assign gc_hit = 1'b0;
`endif

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit7    = 1'b0;
        hit10   = 1'b0;
        idx7    = '0;
        idx10   = '0;
        hdr_hit = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (!addr_is10[i] &&
                (((byte_sr[7:1] ^ addr_table[i][6:0]) & ~addr_mask[i][6:0]) == 7'd0)) begin
                hit7 = 1'b1;
                idx7 = IDX_W'(i);
            end
            hdr_hit[i] = addr_is10[i] &&
                (((byte_sr[2:1] ^ addr_table[i][9:8]) & ~addr_mask[i][9:8]) == 2'd0);
            if (addr_is10[i] &&
                ((({hdr_hi, byte_sr} ^ addr_table[i]) & ~addr_mask[i]) == 10'd0)) begin
                hit10 = 1'b1;
                idx10 = IDX_W'(i);
            end
        end
    end

    // A 10-bit read header is only served for the slot that completed the
    // preceding 10-bit write, and only if its upper address bits still agree.
    assign rs_hit = last10_valid && hdr_hit[last_idx];

    // First-byte decision. A 10-bit header is matched only against 10-bit
    // slots; any other first byte goes through the 7-bit compare.
    always_comb begin
        b1_ack = 1'b0;
        b1_idx = idx7;
        if (gc_hit) begin
            b1_ack = 1'b1;
            b1_idx = '0;
        end else if (!hdr_is10) begin
            b1_ack = hit7;
        end else if (!byte_sr[0]) begin
            b1_ack = |hdr_hit;
        end else begin
            b1_ack = rs_hit;
            b1_idx = last_idx;
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (!rst) begin
            state        <= IDLE;
            done         <= 1'b0;
            selected     <= 1'b0;
            match_idx    <= '0;
            rw           <= 1'b0;
            is_10bit     <= 1'b0;
            ack_drive    <= 1'b0;
            last10_valid <= 1'b0;
            last_idx     <= '0;
            pend_idx     <= '0;
            hdr_mode     <= 1'b0;
            hdr_hi       <= '0;
            byte_sr      <= '0;
`ifdef I2C_GENERAL_CALL_EN
            gen_call     <= 1'b0;
            pend_gc      <= 1'b0;
`endif
        end else if (!enable) begin
            state     <= IDLE;
            done      <= 1'b0;
            selected  <= 1'b0;
            ack_drive <= 1'b0;
`ifdef I2C_GENERAL_CALL_EN
            gen_call  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (cnt_en) begin
                byte_sr <= {byte_sr[6:0], SDA};
            end
            case (state)
                IDLE: begin
                    state     <= BYTE1;
                    selected  <= 1'b0;
                    match_idx <= '0;
                    rw        <= 1'b0;
                    is_10bit  <= 1'b0;
`ifdef I2C_GENERAL_CALL_EN
                    gen_call  <= 1'b0;
`endif
                end
                BYTE1: begin
                    if (byte_end) begin
                        rw       <= byte_sr[0];
                        hdr_hi   <= byte_sr[2:1];
                        hdr_mode <= hdr_is10 && !gc_hit;
`ifdef I2C_GENERAL_CALL_EN
                        pend_gc  <= gc_hit;
`endif
                        if (!hdr_is10 || !b1_ack) begin
                            last10_valid <= 1'b0;
                        end
                        if (b1_ack) begin
                            state     <= ACK1;
                            ack_drive <= 1'b1;
                            pend_idx  <= b1_idx;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (scl_fall) begin
                        ack_drive <= 1'b0;
                        if (hdr_mode && !rw) begin
                            state <= BYTE2;
                        end else begin
                            state     <= FINISH;
                            done      <= 1'b1;
                            selected  <= 1'b1;
                            match_idx <= pend_idx;
                            is_10bit  <= hdr_mode;
`ifdef I2C_GENERAL_CALL_EN
                            gen_call  <= pend_gc;
`endif
                        end
                    end
                end
                BYTE2: begin
                    if (byte_end) begin
                        if (hit10) begin
                            state        <= ACK2;
                            ack_drive    <= 1'b1;
                            pend_idx     <= idx10;
                            last_idx     <= idx10;
                            last10_valid <= 1'b1;
                        end else begin
                            state        <= FINISH;
                            done         <= 1'b1;
                            last10_valid <= 1'b0;
                        end
                    end
                end
                ACK2: begin
                    if (scl_fall) begin
                        ack_drive <= 1'b0;
                        state     <= FINISH;
                        done      <= 1'b1;
                        selected  <= 1'b1;
                        match_idx <= pend_idx;
                        is_10bit  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= FINISH;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_addr_matcher.sv
// tb_i2c_addr_matcher
// Drives I2C address phases bit by bit and compares done / ack / selection
// results against a behavioural model of the address-matching rules.
module tb_i2c_addr_matcher;

    localparam int NUM_ADDR = 4;
    localparam int IDX_W    = 2;

    logic clk = 1'b0;
    logic rst;
    logic SCL;
    logic SCL_prev;
    logic SDA;
    logic enable;
    logic [NUM_ADDR-1:0][9:0] tab;
    logic [NUM_ADDR-1:0][9:0] msk;
    logic [NUM_ADDR-1:0]      is10;
    logic done;
    logic selected;
    logic [IDX_W-1:0] match_idx;
    logic rw;
    logic is_10bit;
    logic ack_drive;
`ifdef I2C_GENERAL_CALL_EN
    logic gen_call;
    logic snap_gc;
`endif

    always #5 clk = ~clk;

    i2c_addr_matcher #(.NUM_ADDR(NUM_ADDR), .IDX_W(IDX_W)) dut (
        .FPGA_clk   (clk),
        .rst        (rst),
        .SCL        (SCL),
        .SCL_prev   (SCL_prev),
        .SDA        (SDA),
        .enable     (enable),
        .addr_table (tab),
        .addr_mask  (msk),
        .addr_is10  (is10),
        .done       (done),
        .selected   (selected),
        .match_idx  (match_idx),
        .rw         (rw),
        .is_10bit   (is_10bit),
        .ack_drive  (ack_drive)
`ifdef I2C_GENERAL_CALL_EN
        ,
        .gen_call   (gen_call)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor state, sampled once per clock at the falling edge
    int step_no = 0;
    int done_cnt, done_step, ack_cnt, ack_first, nfall;
    int fall_at[20];
    logic snap_sel, snap_rw, snap_is10;
    logic [IDX_W-1:0] snap_idx;

    task automatic step(input logic s);
        @(negedge clk);
        step_no++;
        if (done) begin
            done_cnt++;
            done_step = step_no;
            snap_sel  = selected;
            snap_idx  = match_idx;
            snap_rw   = rw;
            snap_is10 = is_10bit;
`ifdef I2C_GENERAL_CALL_EN
            snap_gc   = gen_call;
`endif
        end
        if (ack_drive) begin
            if (ack_cnt == 0) ack_first = step_no;
            ack_cnt++;
        end
        if (SCL && !s) begin
            nfall++;
            if (nfall < 20) fall_at[nfall] = step_no;
        end
        SCL_prev = SCL;
        SCL = s;
    endtask

    task automatic send_bit(input logic b);
        SDA = b;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
    endtask

    task automatic start_txn();
        done_cnt  = 0;
        done_step = 0;
        ack_cnt   = 0;
        ack_first = 0;
        nfall     = 0;
        enable    = 1'b1;
        step(1'b0);
        step(1'b0);
    endtask

    // behavioural reference: rules of the address phase in plain arithmetic
    bit m_last_v   = 0;
    int m_last_idx = 0;
    bit e_sel, e_is10, e_gc, e_ack1, e_byte2, e_ack2;
    int e_idx, e_nend;

    function automatic bit hdr_ok(input int i, input int hi);
        return ((hi ^ (int'(tab[i]) >> 8)) & ~(int'(msk[i]) >> 8) & 3) == 0;
    endfunction

    task automatic model(input logic [7:0] b1, input logic [7:0] b2);
        int a7, hi, full;
        bit any;
        e_sel = 0; e_is10 = 0; e_gc = 0; e_ack1 = 0; e_byte2 = 0; e_ack2 = 0;
        e_idx = 0; e_nend = 8;
        a7   = int'(b1) >> 1;
        hi   = (int'(b1) >> 1) & 3;
        full = hi * 256 + int'(b2);
`ifdef I2C_GENERAL_CALL_EN
        if (b1 == 8'h00) begin
            e_ack1 = 1; e_sel = 1; e_gc = 1; e_nend = 9; m_last_v = 0;
            return;
        end
`endif
        if ((int'(b1) >> 3) != 30) begin
            m_last_v = 0;
            for (int i = 0; i < NUM_ADDR; i++) begin
                if (!is10[i] && ((a7 ^ int'(tab[i])) & ~int'(msk[i]) & 'h7F) == 0) begin
                    e_ack1 = 1; e_sel = 1; e_idx = i; e_nend = 9;
                    break;
                end
            end
        end else if (b1[0] == 1'b0) begin
            any = 0;
            for (int i = 0; i < NUM_ADDR; i++)
                if (is10[i] && hdr_ok(i, hi)) any = 1;
            m_last_v = 0;
            if (any) begin
                e_ack1 = 1; e_byte2 = 1; e_nend = 17;
                for (int i = 0; i < NUM_ADDR; i++) begin
                    if (is10[i] && ((full ^ int'(tab[i])) & ~int'(msk[i]) & 'h3FF) == 0) begin
                        e_ack2 = 1; e_sel = 1; e_is10 = 1; e_idx = i; e_nend = 18;
                        m_last_v = 1; m_last_idx = i;
                        break;
                    end
                end
            end
        end else begin
            if (m_last_v && is10[m_last_idx] && hdr_ok(m_last_idx, hi)) begin
                e_ack1 = 1; e_sel = 1; e_is10 = 1; e_idx = m_last_idx; e_nend = 9;
            end else begin
                m_last_v = 0;
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic [7:0] b1, input logic [7:0] b2);
        int nacks;
        model(b1, b2);
        nacks = int'(e_ack1) + int'(e_ack2);
        start_txn();
        for (int i = 7; i >= 0; i--) send_bit(b1[i]);
        if (e_ack1) send_bit(1'b1);
        if (e_byte2) begin
            for (int i = 7; i >= 0; i--) send_bit(b2[i]);
            if (e_ack2) send_bit(1'b1);
        end
        repeat (4) step(1'b0);
        chk({tag, ".done_n"}, done_cnt, 1);
        chk({tag, ".done_t"}, done_step, fall_at[e_nend] + 1);
        chk({tag, ".ack_n"}, ack_cnt, 6 * nacks);
        if (nacks > 0) chk({tag, ".ack_t"}, ack_first, fall_at[8] + 1);
        chk({tag, ".sel"}, snap_sel, e_sel);
        chk({tag, ".rw"}, snap_rw, b1[0]);
        if (e_sel) begin
            chk({tag, ".idx"}, snap_idx, e_idx);
            chk({tag, ".is10"}, snap_is10, e_is10);
        end
`ifdef I2C_GENERAL_CALL_EN
        chk({tag, ".gc"}, snap_gc, e_gc);
`endif
        chk({tag, ".hold"}, selected, e_sel);
        enable = 1'b0;
        step(1'b0);
        step(1'b0);
        chk({tag, ".rel"}, selected, 0);
    endtask

    initial begin
        logic [7:0] b1, b2;
        int s, mode;
        rst = 1'b0; enable = 1'b0; SCL = 1'b0; SCL_prev = 1'b0; SDA = 1'b1;
        for (int i = 0; i < NUM_ADDR; i++) begin
            tab[i] = 10'h07F; msk[i] = '0; is10[i] = 1'b0;
        end
        repeat (3) step(1'b0);
        chk("rst.done", done, 0);
        chk("rst.sel", selected, 0);
        chk("rst.idx", match_idx, 0);
        chk("rst.rw", rw, 0);
        chk("rst.is10", is_10bit, 0);
        chk("rst.ack", ack_drive, 0);
        rst = 1'b1;
        step(1'b0);

        tab[0] = 10'h042;
        run_txn("r038", 8'h84, 8'h00);
        tab[1] = 10'h2A5; is10[1] = 1'b1;
        run_txn("r039", 8'hF4, 8'hA5);
        run_txn("r040", 8'hF5, 8'h00);
        tab[2] = 10'h042;
        run_txn("lowidx", 8'h84, 8'h00);
        run_txn("w10miss", 8'hF4, 8'h00);
        run_txn("rs_nolast", 8'hF5, 8'h00);
        tab[0] = 10'h040; msk[0] = 10'h003;
        run_txn("mask_hit", 8'h86, 8'h00);
        run_txn("mask_miss", 8'h8A, 8'h00);
        run_txn("gcall", 8'h00, 8'h00);

        // abort after four bits
        tab[0] = 10'h042; msk[0] = '0;
        start_txn();
        for (int i = 7; i >= 4; i--) send_bit(b1_const(i));
        enable = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("abort.ack", ack_drive, 0);
        chk("abort.sel", selected, 0);
        repeat (3) step(1'b0);
        chk("abort.done", done_cnt, 0);
        run_txn("post_abort", 8'h84, 8'h00);

        // reset asserted in the middle of the ACK bit
        start_txn();
        for (int i = 7; i >= 0; i--) send_bit(b1_const(i));
        SDA = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("rstack.pre", ack_drive, 1);
        rst = 1'b0;
        step(1'b1);
        chk("rstack.ack", ack_drive, 0);
        enable = 1'b0;
        step(1'b0);
        rst = 1'b1;
        m_last_v = 0;
        step(1'b0);
        step(1'b0);
        chk("rstack.sel", selected, 0);
        chk("rstack.done", done_cnt, 0);
        run_txn("post_rst", 8'h84, 8'h00);

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NUM_ADDR; i++) begin
                    tab[i]  = 10'($urandom);
                    msk[i]  = 10'($urandom & $urandom & $urandom);
                    is10[i] = ($urandom_range(0, 2) == 0);
                end
            end
            s    = $urandom_range(0, NUM_ADDR - 1);
            mode = $urandom_range(0, 3);
            b1   = 8'($urandom);
            b2   = 8'($urandom);
            if (mode != 0) begin
                if (!is10[s]) begin
                    b1 = {tab[s][6:0] ^ (7'($urandom) & msk[s][6:0]), 1'($urandom)};
                end else begin
                    b1 = {5'b11110, tab[s][9:8], (mode == 3)};
                    b2 = tab[s][7:0] ^ (8'($urandom) & msk[s][7:0]);
                    if ($urandom_range(0, 3) == 0) b2 = b2 ^ 8'(1 << $urandom_range(0, 7));
                end
            end
            run_txn("rnd", b1, b2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // bit i of the fixed byte 8'h84 used by the abort and reset sequences
    function automatic logic b1_const(input int i);
        logic [7:0] v;
        v = 8'h84;
        return v[i];
    endfunction

endmodule
